// File: rtl/mod12_count_ctrl.sv
// Run/stop/step sequencer for an external mod-MOD counter datapath.
// Conditions four raw buttons, derives the count tick from a prescaler, issues registered
// cnt_en / cnt_clr / tc pulses, tracks wrap-arounds and recovers illegal counter values.
module mod12_count_ctrl #(
  parameter int unsigned PRESCALE = 50000000,
  parameter int unsigned MOD      = 12,
  parameter int unsigned CW       = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          btn_start,
  input  logic          btn_stop,
  input  logic          btn_step,
  input  logic          btn_clr,
  input  logic          one_shot,
  input  logic [CW-1:0] cnt_q,
  output logic          cnt_en,
  output logic          cnt_clr,
  output logic          tc,
  output logic [1:0]    state,
  output logic [7:0]    wrap_cnt
);

  localparam int unsigned PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PresMax = PW'(PRESCALE - 1);
  localparam logic [CW-1:0] TermVal = CW'(MOD - 1);

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StRun   = 2'b01,
    StPause = 2'b10,
    StStep  = 2'b11
  } state_e;

  // Button vector order: {clr, step, stop, start}
  logic [3:0] btn_raw;
  logic [3:0] sync1_q, sync2_q, prev_q;
  logic [3:0] btn_edge;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    wrap_q, wrap_d;
  logic          en_q, en_d;
  logic          clr_q, clr_d;
  logic          tc_q, tc_d;

  logic       tick;
  logic       at_term;
  logic       illegal;
  logic [7:0] wrap_inc;

  assign btn_raw  = {btn_clr, btn_step, btn_stop, btn_start};
  assign btn_edge = sync2_q & ~prev_q;

  assign tick     = (state_q == StRun) && (presc_q == PresMax);
  assign at_term  = (cnt_q == TermVal);
  // While a clear is already on its way to the datapath the stale value is not re-flagged.
  assign illegal  = (state_q != StIdle) && (cnt_q > TermVal) && !clr_q;
  assign wrap_inc = (wrap_q == 8'hFF) ? wrap_q : wrap_q + 8'd1;

  // Two-flop synchronizers plus previous-value flop for rising-edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Next-state, prescaler, wrap counter and output-pulse decisions (clr > stop > start > step).
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    wrap_d  = wrap_q;
    en_d    = 1'b0;
    clr_d   = 1'b0;
    tc_d    = 1'b0;
    if (btn_edge[3]) begin
      state_d = StIdle;
      presc_d = '0;
      wrap_d  = '0;
      clr_d   = 1'b1;
    end else if (illegal) begin
      // Drop any pending tick, keep the prescaler free-running in RUN.
      clr_d = 1'b1;
      if (state_q == StRun) begin
        presc_d = tick ? '0 : presc_q + PW'(1);
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          presc_d = '0;
          if (btn_edge[0]) begin
            state_d = StRun;
          end else if (btn_edge[2]) begin
            state_d = StStep;
          end
        end
        StRun: begin
          if (btn_edge[1]) begin
            state_d = StPause;
          end else if (tick) begin
            presc_d = '0;
            en_d    = 1'b1;
            tc_d    = at_term;
            if (at_term) begin
              wrap_d = wrap_inc;
              if (one_shot) begin
                state_d = StPause;
              end
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        StPause: begin
          if (btn_edge[0]) begin
            state_d = StRun;
          end else if (btn_edge[2]) begin
            state_d = StStep;
          end
        end
        StStep: begin
          en_d    = 1'b1;
          tc_d    = at_term;
          state_d = StPause;
          if (at_term) begin
            wrap_d = wrap_inc;
          end
        end
      endcase
    end
  end

  // State and registered outputs; reset drops every output immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      presc_q <= '0;
      wrap_q  <= '0;
      en_q    <= 1'b0;
      clr_q   <= 1'b0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      wrap_q  <= wrap_d;
      en_q    <= en_d;
      clr_q   <= clr_d;
      tc_q    <= tc_d;
    end
  end

  assign cnt_en   = en_q;
  assign cnt_clr  = clr_q;
  assign tc       = tc_q;
  assign state    = state_q;
  assign wrap_cnt = wrap_q;

endmodule

// File: doc/mod12_count_ctrl.md
Name: mod12_count_ctrl

Overview:
Run/stop/step sequencer for the 4-bit mod-12 counter datapath on the FPGA board.
- Conditions the raw push-buttons and derives a slow count tick from the board clock.
- Drives the counter's enable and synchronous-clear inputs, and reads back its current value.
- Flags terminal count, counts wrap-arounds, and recovers the counter from illegal states.

Parameters:
PRESCALE, 50000000, board clocks per count tick in RUN (minimum 2; the bench uses 4).
MOD, 12, counter modulus; terminal value is MOD-1.
CW, 4, counter width; must satisfy 2^CW >= MOD.

Ports:
clk  in  1  board clock; all logic on rising edge.
reset  in  1  asynchronous, active-low reset; reset=0 clears all state immediately.
btn_start  in  1  raw async button, active-high.
btn_stop  in  1  raw async button, active-high.
btn_step  in  1  raw async button, active-high.
btn_clr  in  1  raw async button, active-high.
one_shot  in  1  level; 1 = pause automatically after each wrap.
cnt_q  in  CW  current counter value fed back from the datapath.
cnt_en  out  1  one-cycle count enable to the counter.
cnt_clr  out  1  one-cycle synchronous clear to the counter.
tc  out  1  one-cycle pulse that coincides with the cnt_en that wraps MOD-1 to 0.
state  out  2  IDLE=00, RUN=01, PAUSE=10, STEP=11.
wrap_cnt  out  8  number of wraps since the last clear; saturates at 255.

Behaviour:
- Reset (reset=0, async): state=IDLE, cnt_en=0, cnt_clr=0, tc=0, wrap_cnt=0, prescaler=0, all synchronizer/edge flops=0.
- Button conditioning:
  - Each button passes through a 2-FF synchronizer, then a rising-edge detect (registered previous value).
  - The edge is valid 3 clocks after the raw rise. Holding a button produces exactly one edge.
- Event priority within a cycle: clr > stop > start > step.
- FSM:
  - IDLE: start -> RUN (prescaler=0). step -> STEP. stop ignored.
  - RUN: stop -> PAUSE. start and step ignored.
  - PAUSE: start -> RUN (prescaler resumes from its held value). step -> STEP. stop ignored.
  - STEP: lasts exactly 1 cycle and issues one cnt_en, then -> PAUSE unconditionally.
  - clr in any state: -> IDLE. Asserts cnt_clr for 1 cycle, zeroes prescaler and wrap_cnt. No cnt_en or tc in that cycle.
- Prescaler:
  - Counts 0..PRESCALE-1 only in RUN; holds its value in PAUSE and STEP; zero in IDLE.
  - tick = (prescaler == PRESCALE-1) in RUN; the prescaler wraps to 0 on the same edge.
- Outputs are registered:
  - cnt_en goes high the cycle after a tick, or the cycle after entering STEP, for exactly 1 cycle.
  - Back-to-back cnt_en is impossible, since PRESCALE >= 2.
- tc is registered in the same cycle as cnt_en when cnt_q == MOD-1 at decision time. wrap_cnt increments in that same cycle, saturating at 255.
- one_shot=1 and tc issued in RUN: the next state is PAUSE. The prescaler holds at 0.
- Illegal value recovery (cnt_q >= MOD observed in RUN, PAUSE or STEP):
  - next cycle: cnt_clr=1, cnt_en=0, tc=0; state unchanged; wrap_cnt unchanged.
  - the pending tick is dropped, and the prescaler continues counting.
- Reset asserted mid-RUN: outputs drop within the same cycle, asynchronously. After release the FSM is in IDLE and needs a new start.
- cnt_en and cnt_clr are never high together.

Test Plan:
1. PRESCALE=4: reset, pulse btn_start, cnt_q model counting -> first cnt_en 4 cycles after RUN entry, then every 4 cycles; state=01.
2. Run from cnt_q=0 through 12 enables -> tc high exactly with the 12th cnt_en (cnt_q=11); wrap_cnt=1. Hold 256 wraps -> wrap_cnt stays 255.
3. In RUN, btn_stop with prescaler=2 -> state=10, no cnt_en. btn_start -> the next cnt_en arrives after 1 more cycle (resume from 2, tick at 3). btn_step in PAUSE -> exactly one cnt_en, state 11 for 1 cycle then 10.
4. btn_clr and btn_start rising in the same cycle during RUN -> cnt_clr=1 for 1 cycle, state=00, wrap_cnt=0, no cnt_en.
5. one_shot=1, RUN, cnt_q=11 at tick -> tc with cnt_en, then state=10, no further cnt_en.
6. Force cnt_q=13 in RUN -> cnt_clr pulse the next cycle with cnt_en=0. Reset dropped mid-RUN -> all outputs 0 immediately, state=00 after release.
